// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types and constants for the I2C command arbiter.
// Contents:
//   I2C_DATA_WIDTH      byte width carried in i2c_cmd_t
//   ARB_TIMEOUT_CYCLES  default per-command timeout (optional timeout build only)
//   ARB_CNT_WIDTH       width of the timeout counter
//   arb_state_t         arbiter FSM states
//   i2c_cmd_t           one byte-level command as latched towards the byte master
package i2c_cmd_arbiter_pkg;

    localparam int unsigned I2C_DATA_WIDTH     = 8;
    localparam int unsigned ARB_TIMEOUT_CYCLES = 100000;
    localparam int unsigned ARB_CNT_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        RELEASE
    } arb_state_t;

    typedef struct packed {
        logic                      start;
        logic                      stop;
        logic                      read;
        logic                      write;
        logic                      ack_in;
        logic [I2C_DATA_WIDTH-1:0] din;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Byte-master command bus between the arbiter and the single I2C byte master.
// Signals:
//   start/stop/read/write/ack_in/din  command towards the byte master
//   dout                              read byte from the byte master
//   cmd_ack                           command-done pulse from the byte master
// Modports: master (arbiter side), slave (byte master side).
interface i2c_cmd_arbiter_if
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2C_DATA_WIDTH
);
    logic                  start;
    logic                  stop;
    logic                  read;
    logic                  write;
    logic                  ack_in;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  cmd_ack;

    modport master (
        output start, stop, read, write, ack_in, din,
        input  dout, cmd_ack
    );

    modport slave (
        input  start, stop, read, write, ack_in, din,
        output dout, cmd_ack
    );
endinterface

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
// Ports:
//   req      request vector
//   ptr      highest-priority index
//   gnt_c    one-hot pick (zero when no request)
//   valid_c  any request present
module i2c_rr_pick
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic               valid_c
);

    function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned v);
        return PTR_W'(v % NUM_REQ);
    endfunction

    // Scan from ptr upwards; the first hit wins.
    always_comb begin
        gnt_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((gnt_c == '0) && req[wrap_idx(32'(ptr) + i)]) begin
                gnt_c[wrap_idx(32'(ptr) + i)] = 1'b1;
            end
        end
    end

    assign valid_c = |req;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C byte master between NUM_REQ requesters.
// A grant is locked from the first command until the requester's STOP
// command is acknowledged (or the requester drops req_i while idle).
// Ports:
//   clk_i, arstn_i          clock, async active-low reset
//   req_i / gnt_o           level request / registered one-hot grant
//   r_*_i                   per-requester command bits and write bytes
//   r_cmd_ack_o             per-requester command-done pulse (combinational)
//   r_dout_o                read byte broadcast
//   m_if                    command bus to the byte master (master modport)
//   timeout_o, err_o        timeout pulse and sticky per-requester error
// Optional: define I2C_ARB_TIMEOUT_EN to enable the per-command timeout;
// otherwise timeout_o and err_o are tied low and BUSY waits indefinitely.
// DATA_WIDTH must equal I2C_DATA_WIDTH from the package.
module i2c_cmd_arbiter
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = I2C_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic [NUM_REQ-1:0]            r_start_i,
    input  logic [NUM_REQ-1:0]            r_stop_i,
    input  logic [NUM_REQ-1:0]            r_read_i,
    input  logic [NUM_REQ-1:0]            r_write_i,
    input  logic [NUM_REQ-1:0]            r_ack_in_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] r_din_i,
    output logic [NUM_REQ-1:0]            r_cmd_ack_o,
    output logic [DATA_WIDTH-1:0]         r_dout_o,
    i2c_cmd_arbiter_if.master             m_if,
    output logic                          timeout_o,
    output logic [NUM_REQ-1:0]            err_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("i2c_cmd_arbiter: NUM_REQ must be 2..8");
    end
    if (DATA_WIDTH != I2C_DATA_WIDTH) begin : g_bad_width
        $error("i2c_cmd_arbiter: DATA_WIDTH must match I2C_DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("i2c_cmd_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t          state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    gidx_q;
    i2c_cmd_t            cmd_q;
    i2c_cmd_t            req_cmd_c;
    logic                strobe_c;
    logic [NUM_REQ-1:0]  pick_gnt_c;
    logic                pick_valid_c;

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req_i),
        .ptr     (ptr_q),
        .gnt_c   (pick_gnt_c),
        .valid_c (pick_valid_c)
    );

    // Command presented by the currently granted requester.
    assign req_cmd_c = '{
        start:  r_start_i[gidx_q],
        stop:   r_stop_i[gidx_q],
        read:   r_read_i[gidx_q],
        write:  r_write_i[gidx_q],
        ack_in: r_ack_in_i[gidx_q],
        din:    r_din_i[32'(gidx_q)*DATA_WIDTH +: DATA_WIDTH]
    };
    // A standalone stop is a valid command; start alone is not.
    assign strobe_c = req_cmd_c.read | req_cmd_c.write | req_cmd_c.stop;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [ARB_CNT_WIDTH-1:0] cnt_q;
`endif

    // Arbiter FSM with registered grant and command outputs.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE;
            gnt_o     <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            cmd_q     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_o <= 1'b0;
            err_o     <= '0;
`endif
        end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid_c) begin
                        gnt_o   <= pick_gnt_c;
                        gidx_q  <= onehot_idx(pick_gnt_c);
                        state_q <= GRANT;
`ifdef I2C_ARB_TIMEOUT_EN
                        err_o   <= err_o & ~pick_gnt_c;
`endif
                    end
                end
                GRANT: begin
                    if (strobe_c) begin
                        cmd_q   <= req_cmd_c;
                        state_q <= BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else if (!req_i[gidx_q]) begin
                        gnt_o   <= '0;
                        state_q <= RELEASE;
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle wins over the timeout.
                    if (m_if.cmd_ack) begin
                        cmd_q <= '0;
                        if (cmd_q.stop) begin
                            gnt_o   <= '0;
                            state_q <= RELEASE;
                        end else begin
                            state_q <= GRANT;
                        end
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (cnt_q == ARB_CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        timeout_o     <= 1'b1;
                        err_o[gidx_q] <= 1'b1;
                        cmd_q         <= '0;
                        gnt_o         <= '0;
                        state_q       <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + ARB_CNT_WIDTH'(1);
                    end
`endif
                end
                RELEASE: begin
                    // Last-served requester becomes lowest priority.
                    ptr_q   <= (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef I2C_ARB_TIMEOUT_EN
    assign timeout_o = 1'b0;
    assign err_o     = '0;
`endif

    assign m_if.start  = cmd_q.start;
    assign m_if.stop   = cmd_q.stop;
    assign m_if.read   = cmd_q.read;
    assign m_if.write  = cmd_q.write;
    assign m_if.ack_in = cmd_q.ack_in;
    assign m_if.din    = cmd_q.din;

    assign r_cmd_ack_o = gnt_o & {NUM_REQ{m_if.cmd_ack && (state_q == BUSY)}};
    assign r_dout_o    = m_if.dout;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: a byte-master model acks commands after
// a fixed delay; commands are pushed to a scoreboard when driven and checked
// against the byte-master bus when acknowledged.
module tb_i2c_cmd_arbiter;
    import i2c_cmd_arbiter_pkg::*;

    localparam int unsigned N         = 2;
    localparam int unsigned DW        = 8;
    localparam int unsigned TO        = 50;
    localparam int          ACK_DELAY = 10;

    typedef struct packed {
        logic [12:0]  cmd;
        logic [N-1:0] gnt;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              arstn_i;
    logic [N-1:0]      req;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      r_start, r_stop, r_read, r_write, r_ack_in;
    logic [N*DW-1:0]   r_din;
    logic [N-1:0]      r_cmd_ack_o;
    logic [DW-1:0]     r_dout_o;
    logic              timeout_o;
    logic [N-1:0]      err_o;
    logic [12:0]       m_bits;

    int                total;
    int                bad;
    int                ack_cnt [N];
    logic              ack_en;
    logic [DW-1:0]     dout_val;
    exp_t              sb [$];

    i2c_cmd_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    i2c_cmd_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .r_start_i   (r_start),
        .r_stop_i    (r_stop),
        .r_read_i    (r_read),
        .r_write_i   (r_write),
        .r_ack_in_i  (r_ack_in),
        .r_din_i     (r_din),
        .r_cmd_ack_o (r_cmd_ack_o),
        .r_dout_o    (r_dout_o),
        .m_if        (m_if),
        .timeout_o   (timeout_o),
        .err_o       (err_o)
    );

    assign m_bits = {m_if.start, m_if.stop, m_if.read, m_if.write, m_if.ack_in, m_if.din};

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-master model: acks a held command after ACK_DELAY cycles.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt     = 0;
        m_if.cmd_ack = 1'b0;
        m_if.dout    = '0;
        dout_val     = 8'h5A;
        forever begin
            @(negedge clk_i);
            m_if.cmd_ack = 1'b0;
            if (ack_en && (m_if.read || m_if.write || m_if.stop)) begin
                busy_cnt++;
                if (busy_cnt == ACK_DELAY) begin
                    busy_cnt     = 0;
                    dout_val     = dout_val + 8'h11;
                    m_if.dout    = dout_val;
                    m_if.cmd_ack = 1'b1;
                    #1;
                    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("ack_cmd", 32'(m_bits), 32'(e.cmd));
                        chk("ack_gnt", 32'(r_cmd_ack_o), 32'(e.gnt));
                        chk("dout", 32'(r_dout_o), 32'(dout_val));
                    end
                    for (int i = 0; i < N; i++) begin
                        if (r_cmd_ack_o[i]) ack_cnt[i]++;
                    end
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_strobes();
        r_start  = '0;
        r_stop   = '0;
        r_read   = '0;
        r_write  = '0;
        r_ack_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        arstn_i = 1'b0;
        req     = '0;
        clear_strobes();
        repeat (2) @(negedge clk_i);
        arstn_i = 1'b1;
    endtask

    task automatic strobe(input int n, input logic st, input logic sp, input logic rd,
                          input logic wr, input logic ai, input logic [DW-1:0] d);
        exp_t e;
        @(negedge clk_i);
        r_start[n]        = st;
        r_stop[n]         = sp;
        r_read[n]         = rd;
        r_write[n]        = wr;
        r_ack_in[n]       = ai;
        r_din[n*DW +: DW] = d;
        e.cmd = {st, sp, rd, wr, ai, d};
        e.gnt = N'(1 << n);
        sb.push_back(e);
        @(negedge clk_i);
        clear_strobes();
        chk("latch", 32'(m_bits), 32'(e.cmd));
    endtask

    task automatic wait_ack(input int n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_i);
            #2;
            if (r_cmd_ack_o[n]) got = 1'b1;
        end
        chk("ack_wait", 32'(got), 32'd1);
    endtask

    task automatic do_cmd(input int n, input logic st, input logic sp, input logic rd,
                          input logic wr, input logic ai, input logic [DW-1:0] d);
        strobe(n, st, sp, rd, wr, ai, d);
        wait_ack(n);
        @(negedge clk_i);
        chk("m_clear", 32'(m_bits), 32'd0);
    endtask

    task automatic wait_gnt(output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 50 && g == '0; i++) begin
            @(negedge clk_i);
            g = gnt_o;
        end
    endtask

    initial begin
        logic [N-1:0] g;
        logic         odd;
        int           a0;
        int           a1;
        int           busy;
        logic         seen_to;
        total    = 0;
        bad      = 0;
        ack_en   = 1'b1;
        ack_cnt  = '{default: 0};
        arstn_i  = 1'b0;
        req      = '0;
        r_din    = '0;
        clear_strobes();
        repeat (2) @(negedge clk_i);

        // Reset values.
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_m", 32'(m_bits), 32'd0);
        chk("rst_cmd_ack", 32'(r_cmd_ack_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        arstn_i = 1'b1;

        // Single requester, three-byte write transaction.
        @(negedge clk_i);
        req = 2'b01;
        @(negedge clk_i);
        chk("t1_gnt_latency", 32'(gnt_o), 32'h1);
        a0 = ack_cnt[0];
        do_cmd(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE8);
        do_cmd(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        do_cmd(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h23);
        chk("t1_release_gnt", 32'(gnt_o), 32'd0);
        req = 2'b00;
        chk("t1_ack_count", 32'(ack_cnt[0] - a0), 32'd3);
        @(negedge clk_i);
        chk("t1_idle_gnt", 32'(gnt_o), 32'd0);

        // Both request from reset: r0 first, then strict alternation.
        do_reset();
        req = 2'b11;
        @(negedge clk_i);
        chk("t2_first_gnt", 32'(gnt_o), 32'h1);
        for (int t = 0; t < 4; t++) begin
            odd = 1'(t % 2);
            chk("t3_alt_gnt", 32'(gnt_o), 32'(1 << (t % 2)));
            do_cmd(t % 2, 1'b1, 1'b1, odd, ~odd, odd, DW'(8'h40 + t));
            chk("t2_release_gap", 32'(gnt_o), 32'd0);
            if (t == 3) req = 2'b00;
            @(negedge clk_i);
            chk("t2_idle_gap", 32'(gnt_o), 32'd0);
            if (t < 3) @(negedge clk_i);
        end

        // Non-granted requester strobes while r0 is busy.
        req = 2'b01;
        wait_gnt(g);
        chk("t4_gnt", 32'(g), 32'h1);
        a1 = ack_cnt[1];
        strobe(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        @(negedge clk_i);
        r_write[1]  = 1'b1;
        r_stop[1]   = 1'b1;
        r_din[15:8] = 8'hAA;
        @(negedge clk_i);
        clear_strobes();
        chk("t4_m_hold", 32'(m_bits), 32'({5'b00010, 8'h77}));
        wait_ack(0);
        chk("t4_no_r1_ack", 32'(ack_cnt[1] - a1), 32'd0);
        @(negedge clk_i);
        chk("t4_m_clear", 32'(m_bits), 32'd0);
        chk("t4_still_gnt", 32'(gnt_o), 32'h1);
        do_cmd(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t4_stop_release", 32'(gnt_o), 32'd0);
        req = 2'b00;

        // Grant dropped without a command moves the pointer past r0.
        do_reset();
        req = 2'b01;
        wait_gnt(g);
        chk("t5_gnt", 32'(g), 32'h1);
        req = 2'b00;
        @(negedge clk_i);
        chk("t5_release", 32'(gnt_o), 32'd0);
        req = 2'b11;
        wait_gnt(g);
        chk("t5_ptr_moved", 32'(g), 32'h2);
        req = 2'b00;
        @(negedge clk_i);
        chk("t5_r1_release", 32'(gnt_o), 32'd0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never acks: timeout after TO busy cycles.
        ack_en = 1'b0;
        @(negedge clk_i);
        req = 2'b01;
        wait_gnt(g);
        chk("t6_gnt", 32'(g), 32'h1);
        strobe(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        busy    = 1;
        seen_to = 1'b0;
        for (int i = 0; i < 80 && !seen_to; i++) begin
            @(negedge clk_i);
            if (timeout_o) seen_to = 1'b1;
            else if (m_bits != '0) busy++;
        end
        chk("t6_timeout_seen", 32'(seen_to), 32'd1);
        chk("t6_busy_cycles", 32'(busy), 32'(TO));
        chk("t6_err", 32'(err_o), 32'h1);
        chk("t6_m_cleared", 32'(m_bits), 32'd0);
        chk("t6_gnt_dropped", 32'(gnt_o), 32'd0);
        @(negedge clk_i);
        chk("t6_pulse_one", 32'(timeout_o), 32'd0);
        chk("t6_err_sticky", 32'(err_o), 32'h1);
        void'(sb.pop_back());
        ack_en = 1'b1;
        wait_gnt(g);
        chk("t6_regnt", 32'(g), 32'h1);
        chk("t6_err_cleared", 32'(err_o), 32'd0);
        do_cmd(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        req = 2'b00;
`else
        chk("no_timeout", 32'(timeout_o), 32'd0);
        chk("no_err", 32'(err_o), 32'd0);
`endif

        repeat (3) @(negedge clk_i);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
